stoper_ctrl: RTL and testbench
==============================

Name: stoper_ctrl

Overview:
- Stopwatch control and timebase stage, directly downstream of the button debouncer.
- Consumes the debounced level outputs of two debouncer instances:
  - start/stop button;
  - lap/reset button.
- Runs the start/stop/lap/reset state machine and a prescaled BCD time counter (MM:SS.cc).
- Presents live or lap-frozen time to the display driver.

Parameters:
- CLK_DIV, 500000, clk cycles per 10 ms tick. Minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_ss  in  1  debounced start/stop level, 1 = pressed.
- btn_lr  in  1  debounced lap/reset level, 1 = pressed.
- run  out  1  1 in RUN or LAP.
- lap  out  1  1 in LAP; display is frozen.
- cs  out  8  BCD centiseconds 00-99, [7:4] tens, [3:0] units.
- sec  out  8  BCD seconds 00-59.
- min  out  8  BCD minutes 00-99.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; time, lap-latch and prescaler = 0.
  - run=lap=ovf=0; cs=sec=min=8'h00.
  - Edge registers ss_q=lr_q=1, so a button held through reset produces no event.
- Edge detect:
  - ss_ev = btn_ss & ~ss_q; lr_ev = btn_lr & ~lr_q.
  - ss_q/lr_q are sampled every clk.
  - Each event is exactly one cycle per press, regardless of hold length.
- Simultaneous ss_ev and lr_ev: ss_ev is acted on, lr_ev is discarded.
- State transitions (take effect at the edge where the event is seen; outputs update the same edge):
  - IDLE: ss_ev -> RUN. lr_ev ignored.
  - RUN: ss_ev -> STOP. lr_ev -> LAP; copy live time into lap-latch.
  - LAP: ss_ev -> STOP; display returns to live time. lr_ev -> RUN; display returns to live time.
  - STOP: ss_ev -> RUN, only if ovf=0; otherwise ignored. lr_ev -> IDLE; clear time, prescaler and ovf.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN and LAP.
  - tick=1 on the cycle the count equals CLK_DIV-1; count then wraps to 0.
  - Holds its value in STOP, so resume is phase-continuous.
  - Is 0 in IDLE.
- Time counter:
  - Increments by one centisecond on tick.
  - Each BCD digit wraps at its limit with carry: cs units 9, cs tens 9, sec units 9, sec tens 5, min units 9, min tens 9.
  - Counting continues in LAP.
  - No non-BCD digit value is ever produced.
- Overflow:
  - Condition: tick while time = 99:59.99.
  - Time holds at 99:59.99, ovf=1, state forced to STOP; this applies from RUN or LAP.
  - ovf is cleared only by STOP -> IDLE or by reset.
- Output mux: cs/sec/min = lap-latch when state=LAP, else live time. All outputs are driven from registers; no combinational path from btn_* to outputs.
- Async reset mid-count: immediate return to reset values; no event is generated on release.

Test Plan:
- Reset, then btn_ss pulse high for 3 cycles, with CLK_DIV=4 -> run=1 one edge after first sample; cs=8'h01 after 4 clks; hold length gives a single event only.
- RUN for 6000 ticks, then ss press -> time reads sec=8'h00, min=8'h01, cs=8'h00; run=0; after 20 idle clks, time unchanged and prescaler unchanged.
- In RUN at cs=8'h37, lr press -> lap=1 and display frozen at 8'h37 while live count advances. Second lr press -> lap=0 and display shows live value (e.g. 8'h52 after 15 further ticks).
- STOP state, lr press -> IDLE; cs=sec=min=0; then ss and lr asserted on the same cycle from RUN -> STOP only, no lap latch.
- Preload near 99:59.98, run 2 ticks -> 99:59.99 then ovf=1, run=0, time held. ss press ignored; lr press -> IDLE, ovf=0, time 00:00.00.
- Assert rst_n=0 mid-RUN with btn_ss held high, release -> all outputs 0, state IDLE, no start until btn_ss is released and pressed again.

Source files
------------

// File: rtl/stoper_ctrl.sv
// Purpose : stopwatch control FSM (IDLE/RUN/LAP/STOP) plus prescaled BCD MM:SS.cc timebase.
// Latency : a button press is acted on at the first clk edge that samples it; outputs update on that edge.
// Backpres: none; button events are single-cycle pulses and are never queued or delayed.
//
// Ports:
//   clk     - system clock, all state on rising edge
//   rst_n   - asynchronous active-low reset
//   btn_ss  - debounced start/stop level (1 = pressed)
//   btn_lr  - debounced lap/reset level (1 = pressed)
//   run     - 1 while counting (RUN or LAP)
//   lap     - 1 while the display is frozen on the lap value
//   cs/sec/min - BCD display time (lap-latched in LAP, live otherwise)
//   ovf     - sticky overflow, set when counting past 99:59.99
module stoper_ctrl #(
    parameter int CLK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       run,
    output logic       lap,
    output logic [7:0] cs,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       ovf
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            ss_q;
    logic            lr_q;
    logic            ss_ev;
    logic            lr_ev;

    logic [PW-1:0]   presc;
    logic            counting;
    logic            tick;

    logic [7:0]      live_cs;
    logic [7:0]      live_sec;
    logic [7:0]      live_min;
    logic [7:0]      lap_cs;
    logic [7:0]      lap_sec;
    logic [7:0]      lap_min;

    logic [8:0]      cs_inc;
    logic [8:0]      sec_inc;
    logic [8:0]      min_inc;
    logic            at_max;
    logic            ovf_hit;
    logic            do_clear;
    logic            do_latch;

    // Two-digit BCD increment. Bit 8 is the carry out; the result wraps to
    // 00 when the value is at its top (x9 with tens == tens_max).
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [8:0] r;
        if (v[3:0] != 4'd9) begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != tens_max) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = 9'h100;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Button edge detect. The history flops reset to 1 so a button that is
    // held through reset looks "already pressed" and yields no event.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q <= 1'b1;
            lr_q <= 1'b1;
        end else begin
            ss_q <= btn_ss;
            lr_q <= btn_lr;
        end
    end

    assign ss_ev = btn_ss & ~ss_q;
    // Start/stop wins a same-cycle collision; the lap/reset event is dropped.
    assign lr_ev = btn_lr & ~lr_q & ~ss_ev;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    assign counting = (state == S_RUN) || (state == S_LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    assign cs_inc  = bcd_inc(live_cs,  4'd9);
    assign sec_inc = bcd_inc(live_sec, 4'd5);
    assign min_inc = bcd_inc(live_min, 4'd9);

    // 99:59.99 is exactly the point where every digit pair carries out.
    assign at_max  = cs_inc[8] & sec_inc[8] & min_inc[8];
    assign ovf_hit = tick & at_max;

    assign do_clear = (state == S_STOP) && lr_ev;
    assign do_latch = (state == S_RUN) && (state_nxt == S_LAP);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ss_ev) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (ss_ev)      state_nxt = S_STOP;
                else if (lr_ev) state_nxt = S_LAP;
            end
            S_LAP: begin
                if (ss_ev)      state_nxt = S_STOP;
                else if (lr_ev) state_nxt = S_RUN;
            end
            S_STOP: begin
                // An overflowed run cannot be resumed, only cleared.
                if (ss_ev && !ovf) state_nxt = S_RUN;
                else if (lr_ev)    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Overflow overrides any button event in the same cycle.
        if (ovf_hit) state_nxt = S_STOP;
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state and registered time)
    // ------------------------------------------------------------------
    always_comb begin
        run = counting;
        lap = (state == S_LAP);
        if (state == S_LAP) begin
            cs  = lap_cs;
            sec = lap_sec;
            min = lap_min;
        end else begin
            cs  = live_cs;
            sec = live_sec;
            min = live_min;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, live time, lap latch and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            live_cs  <= 8'h00;
            live_sec <= 8'h00;
            live_min <= 8'h00;
            lap_cs   <= 8'h00;
            lap_sec  <= 8'h00;
            lap_min  <= 8'h00;
            ovf      <= 1'b0;
        end else begin
            // Prescaler only moves while counting; in STOP it keeps its
            // phase so a resume continues the partially elapsed tick.
            if (do_clear || state == S_IDLE) begin
                presc <= '0;
            end else if (counting) begin
                presc <= tick ? '0 : presc + PW'(1);
            end

            if (do_clear) begin
                live_cs  <= 8'h00;
                live_sec <= 8'h00;
                live_min <= 8'h00;
            end else if (tick && !ovf_hit) begin
                live_cs <= cs_inc[7:0];
                if (cs_inc[8]) begin
                    live_sec <= sec_inc[7:0];
                    if (sec_inc[8]) begin
                        live_min <= min_inc[7:0];
                    end
                end
            end

            // The latch captures the time shown up to this edge.
            if (do_latch) begin
                lap_cs  <= live_cs;
                lap_sec <= live_sec;
                lap_min <= live_min;
            end

            if (do_clear) begin
                ovf <= 1'b0;
            end else if (ovf_hit) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stoper_ctrl.sv
// Purpose : bench for stoper_ctrl; integer-centisecond reference model plus directed button sequences.
// Latency : model advances on the same clk edges as the design; outputs compared 2 time units after negedge.
// Backpres: none.
module tb_stoper_ctrl;

    localparam int DIV  = 4;
    localparam int TMAX = 599999;   // 99:59.99 in centiseconds

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       run;
    logic       lap;
    logic [7:0] cs;
    logic [7:0] sec;
    logic [7:0] min;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    stoper_ctrl #(.CLK_DIV(DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_ss (btn_ss),
        .btn_lr (btn_lr),
        .run    (run),
        .lap    (lap),
        .cs     (cs),
        .sec    (sec),
        .min    (min),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: time as a plain centisecond count.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

    int m_st  = M_IDLE;
    int m_t   = 0;
    int m_lt  = 0;
    int m_pre = 0;
    bit m_ovf = 1'b0;
    bit m_ssq = 1'b1;
    bit m_lrq = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        bit ss;
        bit lr;
        bit cnt;
        bit tk;
        int ns;
        if (!rst_n) begin
            m_st  = M_IDLE;
            m_t   = 0;
            m_lt  = 0;
            m_pre = 0;
            m_ovf = 1'b0;
            m_ssq = 1'b1;
            m_lrq = 1'b1;
        end else begin
            ss  = btn_ss && !m_ssq;
            lr  = btn_lr && !m_lrq && !ss;
            m_ssq = btn_ss;
            m_lrq = btn_lr;
            cnt = (m_st == M_RUN) || (m_st == M_LAP);
            tk  = cnt && (m_pre == DIV - 1);
            ns  = m_st;
            case (m_st)
                M_IDLE: if (ss) ns = M_RUN;
                M_RUN: begin
                    if (ss) ns = M_STOP;
                    else if (lr) begin
                        ns   = M_LAP;
                        m_lt = m_t;
                    end
                end
                M_LAP: begin
                    if (ss) ns = M_STOP;
                    else if (lr) ns = M_RUN;
                end
                default: begin
                    if (ss && !m_ovf) ns = M_RUN;
                    else if (lr) begin
                        ns    = M_IDLE;
                        m_t   = 0;
                        m_pre = 0;
                        m_ovf = 1'b0;
                    end
                end
            endcase
            if (cnt) m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
                if (m_t == TMAX) begin
                    m_ovf = 1'b1;
                    ns    = M_STOP;
                end else begin
                    m_t = m_t + 1;
                end
            end
            m_st = ns;
        end
    end

    function automatic logic [7:0] bcd(input int x);
        return 8'(((x / 10) * 16) + (x % 10));
    endfunction

    function automatic logic [26:0] model_out();
        int d;
        d = (m_st == M_LAP) ? m_lt : m_t;
        return {(m_st == M_RUN || m_st == M_LAP), (m_st == M_LAP), m_ovf,
                bcd(d / 6000), bcd((d / 100) % 60), bcd(d % 100)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        #2;
        chk("model {run,lap,ovf,min,sec,cs}", {5'b0, run, lap, ovf, min, sec, cs},
            {5'b0, model_out()});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        step(1);
        btn_ss = 1'b0;
        step(1);
    endtask

    task automatic press_lr();
        btn_lr = 1'b1;
        step(1);
        btn_lr = 1'b0;
        step(1);
    endtask

    // Bounded wait for the model to reach a centisecond count; exits right
    // after the tick edge, so a press issued next is never tick-coincident.
    task automatic wait_t(input int target);
        for (int i = 0; i < 40000 && m_t != target; i++) step(1);
        if (m_t != target) chk("wait_timeout", m_t, target);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        #2 rst_n = 1'b0;
        step(3);
        chk("rst_run",  run, 0);
        chk("rst_lap",  lap, 0);
        chk("rst_ovf",  ovf, 0);
        chk("rst_time", {min, sec, cs}, 24'h000000);
        rst_n = 1'b1;
        step(2);
        chk("idle_run", run, 0);

        // Start, holding start/stop for three edges.
        btn_ss = 1'b1;
        step(1);
        chk("start_run", run, 1);
        chk("start_cs", cs, 8'h00);
        step(2);
        btn_ss = 1'b0;
        step(1);
        chk("pre_tick_cs", cs, 8'h00);
        step(1);
        chk("first_tick_cs", cs, 8'h01);
        chk("single_event", run, 1);

        // One minute, then stop.
        wait_t(6000);
        chk("minute_time", {min, sec, cs}, 24'h010000);
        press_ss();
        chk("stop_run", run, 0);
        chk("stop_time", {min, sec, cs}, 24'h010000);
        chk("stop_presc", 32'(dut.presc), 1);
        step(20);
        chk("stop_hold_time", {min, sec, cs}, 24'h010000);
        chk("stop_hold_presc", 32'(dut.presc), 1);

        // Resume, lap at .37, release at .52.
        press_ss();
        chk("resume_run", run, 1);
        wait_t(6037);
        press_lr();
        chk("lap_on", lap, 1);
        chk("lap_cs", cs, 8'h37);
        wait_t(6045);
        chk("lap_frozen", cs, 8'h37);
        wait_t(6052);
        press_lr();
        chk("lap_off", lap, 0);
        chk("lap_live_cs", cs, 8'h52);
        chk("lap_live_run", run, 1);

        // Stop then clear.
        press_ss();
        chk("stop2_run", run, 0);
        press_lr();
        chk("clear_time", {min, sec, cs}, 24'h000000);
        chk("clear_presc", 32'(dut.presc), 0);
        chk("clear_run", run, 0);

        // Both buttons on one edge: start/stop only.
        press_ss();
        wait_t(20);
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        step(1);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        chk("both_run", run, 0);
        chk("both_lap", lap, 0);
        chk("both_cs", cs, 8'h20);

        // Preload 99:59.98 while stopped, then run into overflow.
        force dut.live_cs  = 8'h98;
        force dut.live_sec = 8'h59;
        force dut.live_min = 8'h99;
        m_t = TMAX - 1;
        step(1);
        release dut.live_cs;
        release dut.live_sec;
        release dut.live_min;
        step(1);
        chk("preload", {min, sec, cs}, 24'h995998);
        press_ss();
        wait_t(TMAX);
        chk("max_time", {min, sec, cs}, 24'h995999);
        chk("max_ovf", ovf, 0);
        step(DIV);
        chk("ovf_set", ovf, 1);
        chk("ovf_run", run, 0);
        chk("ovf_time", {min, sec, cs}, 24'h995999);
        press_ss();
        chk("ovf_no_resume", run, 0);
        chk("ovf_hold_time", {min, sec, cs}, 24'h995999);
        press_lr();
        chk("ovf_clear", ovf, 0);
        chk("ovf_clear_time", {min, sec, cs}, 24'h000000);

        // Async reset mid-run with start/stop held through release.
        press_ss();
        step(10);
        rst_n  = 1'b0;
        btn_ss = 1'b1;
        #1;
        chk("async_run", run, 0);
        chk("async_time", {min, sec, cs}, 24'h000000);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("held_no_start", run, 0);
        btn_ss = 1'b0;
        step(1);
        btn_ss = 1'b1;
        step(1);
        btn_ss = 1'b0;
        chk("restart_run", run, 1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
